// File: rtl/spi_pkg.sv
// Shared constants and helpers for the SPI slave path.
package spi_pkg;

  // {CPOL, CPHA} encodings of the four SPI modes.
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  // Bit positions inside the mode field.
  localparam int unsigned CPOL_BIT = 1;
  localparam int unsigned CPHA_BIT = 0;

  // Width of the per-word bit counter.
  function automatic int unsigned cnt_w(input int unsigned data_w);
    return $clog2(data_w);
  endfunction

endpackage

// File: rtl/spi_sync.sv
// N-stage synchroniser with registered rise/fall pulses. The pulses compare the
// last synchroniser stage against one extra history flop, so a pin edge shows
// up as a pulse Stages+1 clocks later.
module spi_sync #(
  parameter int unsigned Stages   = 2,
  parameter logic        ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [Stages:0] chain_q;
  logic            rise_q;
  logic            fall_q;

  // Shift the pin through the chain and register the edge pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      chain_q <= {(Stages + 1){ResetVal}};
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      chain_q <= {chain_q[Stages-1:0], d_i};
      rise_q  <= chain_q[Stages-1] & ~chain_q[Stages];
      fall_q  <= ~chain_q[Stages-1] & chain_q[Stages];
    end
  end

  assign q_o    = chain_q[Stages-1];
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/spi_slave_core.sv
// SPI slave: runtime-selectable mode latched per frame, configurable word width
// and bit order, one-word TX holding register, RX valid/ready, sticky errors.
module spi_slave_core
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned LSB_FIRST   = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      PRESET,
  input  logic                      SCK,
  input  logic                      SSEL,
  input  logic                      MOSI,
  output logic                      MISO,
  output logic                      MISO_oe,
  input  logic [1:0]                mode,
  input  logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic [DATA_W-1:0]         rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic [cnt_w(DATA_W)-1:0]  bit_cnt,
  output logic                      frame_active,
  output logic                      tx_underrun,
  output logic                      rx_overrun,
  input  logic                      err_clr
);

  localparam int unsigned       CntW     = cnt_w(DATA_W);
  localparam logic [CntW-1:0]   CntMax   = CntW'(DATA_W - 1);
  localparam int unsigned       MisoIdx  = (LSB_FIRST != 0) ? 0 : DATA_W - 1;
  localparam int unsigned       SettleW  = $clog2(SYNC_STAGES + 1);
  localparam logic [SettleW-1:0] SettleMax = SettleW'(SYNC_STAGES);

  logic sck_lvl, sck_rise, sck_fall;
  logic ssel_lvl, ssel_rise, ssel_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  spi_sync #(.Stages(SYNC_STAGES), .ResetVal(1'b0)) u_sync_sck (
    .clk_i (clk), .rst_i (PRESET), .d_i (SCK),
    .q_o (sck_lvl), .rise_o (sck_rise), .fall_o (sck_fall)
  );

  spi_sync #(.Stages(SYNC_STAGES), .ResetVal(1'b1)) u_sync_ssel (
    .clk_i (clk), .rst_i (PRESET), .d_i (SSEL),
    .q_o (ssel_lvl), .rise_o (ssel_rise), .fall_o (ssel_fall)
  );

  spi_sync #(.Stages(SYNC_STAGES), .ResetVal(1'b0)) u_sync_mosi (
    .clk_i (clk), .rst_i (PRESET), .d_i (MOSI),
    .q_o (mosi_lvl), .rise_o (mosi_rise), .fall_o (mosi_fall)
  );

  // Frame end is taken from the SSEL level, so its edge pulse is not needed.
  logic unused_edges;
  assign unused_edges = ^{sck_lvl, ssel_rise, mosi_rise, mosi_fall};

  logic [1:0]          mode_q, mode_d;
  logic                active_q, active_d;
  logic [CntW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic [DATA_W-1:0]   tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                hold_full_q, hold_full_d;
  logic                underrun_q, underrun_d;
  logic                overrun_q, overrun_d;
  // armed_q blocks a frame from starting until SSEL has been seen idle after
  // reset; settle_q waits for the synchroniser to flush its reset value.
  logic                armed_q, armed_d;
  logic [SettleW-1:0]  settle_q, settle_d;

  logic frame_start, lead_ev, trail_ev, sample_ev, shift_ev, load_ev;
  logic [DATA_W-1:0] rx_next, tx_next;

  assign frame_start = ssel_fall & armed_q & ~ssel_lvl;
  assign lead_ev     = mode_q[CPOL_BIT] ? sck_fall : sck_rise;
  assign trail_ev    = mode_q[CPOL_BIT] ? sck_rise : sck_fall;
  assign sample_ev   = active_q & ~ssel_lvl & (mode_q[CPHA_BIT] ? trail_ev : lead_ev);
  assign shift_ev    = active_q & ~ssel_lvl & (mode_q[CPHA_BIT] ? lead_ev : trail_ev);
  assign load_ev     = (frame_start & ~mode[CPHA_BIT]) | (shift_ev & (bit_cnt_q == '0));

  // Shifted versions of the RX and TX registers for the configured bit order.
  always_comb begin
    rx_next = rx_shift_q;
    tx_next = tx_shift_q;
    if (LSB_FIRST != 0) begin
      rx_next = {mosi_lvl, rx_shift_q[DATA_W-1:1]};
      tx_next = {1'b0, tx_shift_q[DATA_W-1:1]};
    end else begin
      rx_next = {rx_shift_q[DATA_W-2:0], mosi_lvl};
      tx_next = {tx_shift_q[DATA_W-2:0], 1'b0};
    end
  end

  // Next-state logic for framing, RX/TX datapath, handshakes and error flags.
  always_comb begin
    mode_d      = mode_q;
    active_d    = active_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    tx_shift_d  = tx_shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    underrun_d  = underrun_q & ~err_clr;
    overrun_d   = overrun_q & ~err_clr;
    armed_d     = armed_q;
    settle_d    = settle_q;

    if (settle_q != SettleMax) begin
      settle_d = settle_q + 1'b1;
    end else if (ssel_lvl) begin
      armed_d = 1'b1;
    end

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    if (frame_start) begin
      mode_d    = mode;
      active_d  = 1'b1;
      bit_cnt_d = '0;
    end

    if (sample_ev) begin
      rx_shift_d = rx_next;
      bit_cnt_d  = (bit_cnt_q == CntMax) ? '0 : bit_cnt_q + 1'b1;
      if (bit_cnt_q == CntMax) begin
        // A word completing alongside the handshake replaces the popped one.
        if (!rx_valid_q || rx_ready) begin
          rx_data_d  = rx_next;
          rx_valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end
    end

    if (load_ev) begin
      if (hold_full_q) begin
        tx_shift_d  = hold_q;
        hold_full_d = 1'b0;
      end else begin
        tx_shift_d = '0;
        underrun_d = 1'b1;
      end
    end else if (shift_ev) begin
      tx_shift_d = tx_next;
    end

    // SSEL seen high ends the frame and discards any partial word.
    if (ssel_lvl) begin
      active_d  = 1'b0;
      bit_cnt_d = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge PRESET) begin
    if (PRESET) begin
      mode_q      <= '0;
      active_q    <= 1'b0;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_shift_q  <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      underrun_q  <= 1'b0;
      overrun_q   <= 1'b0;
      armed_q     <= 1'b0;
      settle_q    <= '0;
    end else begin
      mode_q      <= mode_d;
      active_q    <= active_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_shift_q  <= tx_shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      underrun_q  <= underrun_d;
      overrun_q   <= overrun_d;
      armed_q     <= armed_d;
      settle_q    <= settle_d;
    end
  end

  assign MISO         = active_q & tx_shift_q[MisoIdx];
  assign MISO_oe      = active_q;
  assign tx_ready     = ~hold_full_q;
  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign bit_cnt      = bit_cnt_q;
  assign frame_active = active_q;
  assign tx_underrun  = underrun_q;
  assign rx_overrun   = overrun_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench: an 8-bit MSB-first slave (A) and a 16-bit LSB-first slave (B)
// share SCK/MOSI and are driven by a bit-banged master.
module tb_spi_slave_core;
  import spi_pkg::*;

  localparam int H = 8;  // SCK half period in clk cycles

  logic clk;
  logic PRESET;
  logic sck, mosi, err_clr;
  logic ssel_a, ssel_b;
  logic miso_a, miso_oe_a, miso_b, miso_oe_b;
  logic [1:0] mode_a, mode_b;
  logic [7:0] tx_data_a, rx_data_a;
  logic [15:0] tx_data_b, rx_data_b;
  logic tx_valid_a, tx_ready_a, rx_valid_a, rx_ready_a;
  logic tx_valid_b, tx_ready_b, rx_valid_b, rx_ready_b;
  logic [2:0] bit_cnt_a;
  logic [3:0] bit_cnt_b;
  logic frame_active_a, tx_underrun_a, rx_overrun_a;
  logic frame_active_b, tx_underrun_b, rx_overrun_b;

  int n_vec = 0;
  int n_err = 0;

  spi_slave_core #(.DATA_W(8), .LSB_FIRST(0), .SYNC_STAGES(2)) u_dut_a (
    .clk(clk), .PRESET(PRESET), .SCK(sck), .SSEL(ssel_a), .MOSI(mosi),
    .MISO(miso_a), .MISO_oe(miso_oe_a), .mode(mode_a),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
    .bit_cnt(bit_cnt_a), .frame_active(frame_active_a),
    .tx_underrun(tx_underrun_a), .rx_overrun(rx_overrun_a), .err_clr(err_clr)
  );

  spi_slave_core #(.DATA_W(16), .LSB_FIRST(1), .SYNC_STAGES(2)) u_dut_b (
    .clk(clk), .PRESET(PRESET), .SCK(sck), .SSEL(ssel_b), .MOSI(mosi),
    .MISO(miso_b), .MISO_oe(miso_oe_b), .mode(mode_b),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
    .bit_cnt(bit_cnt_b), .frame_active(frame_active_b),
    .tx_underrun(tx_underrun_b), .rx_overrun(rx_overrun_b), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One master transfer of nbits; split stops right after the last leading
  // edge (CPHA=0 only) so the caller can observe completion timing.
  task automatic spi_xfer(input bit sel, input logic [1:0] md, input int nbits, input int width,
                          input bit lsb, input logic [15:0] mosi_w, input bit split,
                          output logic [15:0] miso_w);
    logic cpol, cpha;
    cpol   = md[1];
    cpha   = md[0];
    miso_w = '0;
    for (int i = 0; i < nbits; i++) begin
      int idx;
      idx = lsb ? i : width - 1 - i;
      if (!cpha) begin
        mosi = mosi_w[idx];
        tick(H);
        miso_w[idx] = sel ? miso_b : miso_a;
        sck = ~cpol;
        if (!(split && i == nbits - 1)) begin
          tick(H);
          sck = cpol;
        end
      end else begin
        sck  = ~cpol;
        mosi = mosi_w[idx];
        tick(H);
        miso_w[idx] = sel ? miso_b : miso_a;
        sck = cpol;
        tick(H);
      end
    end
  endtask

  // Mode is changed after the frame starts to show it is latched.
  task automatic frame_begin(input bit sel, input logic [1:0] md);
    sck = md[1];
    if (sel) mode_b = md; else mode_a = md;
    tick(6);
    if (sel) ssel_b = 1'b0; else ssel_a = 1'b0;
    tick(10);
    if (sel) mode_b = ~md; else mode_a = ~md;
  endtask

  task automatic frame_end(input bit sel);
    tick(H);
    if (sel) ssel_b = 1'b1; else ssel_a = 1'b1;
    tick(10);
  endtask

  task automatic tx_push(input logic [7:0] d);
    int t;
    t = 0;
    while (!tx_ready_a && t < 400) begin
      tick(1);
      t++;
    end
    n_vec++;
    if (tx_ready_a !== 1'b1) begin
      n_err++;
      $display("FAIL tx_push_ready got %b want 1", tx_ready_a);
    end else begin
      tx_data_a  = d;
      tx_valid_a = 1'b1;
      tick(1);
      tx_valid_a = 1'b0;
    end
  endtask

  task automatic rx_pop();
    rx_ready_a = 1'b1;
    tick(1);
    rx_ready_a = 1'b0;
  endtask

  task automatic err_pulse();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    tick(3);
    n_vec++;
    if ({miso_a, miso_oe_a, rx_valid_a, tx_ready_a, frame_active_a, tx_underrun_a,
         rx_overrun_a, rx_data_a, bit_cnt_a} !== {7'b0001000, 8'h00, 3'd0}) begin
      n_err++;
      $display("FAIL reset_a got %b want %b", {miso_a, miso_oe_a, rx_valid_a, tx_ready_a,
               frame_active_a, tx_underrun_a, rx_overrun_a, rx_data_a, bit_cnt_a},
               {7'b0001000, 8'h00, 3'd0});
    end
    n_vec++;
    if ({miso_b, miso_oe_b, rx_valid_b, tx_ready_b, frame_active_b, tx_underrun_b,
         rx_overrun_b, rx_data_b, bit_cnt_b} !== {7'b0001000, 16'h0000, 4'd0}) begin
      n_err++;
      $display("FAIL reset_b got %b want %b", {miso_b, miso_oe_b, rx_valid_b, tx_ready_b,
               frame_active_b, tx_underrun_b, rx_overrun_b, rx_data_b, bit_cnt_b},
               {7'b0001000, 16'h0000, 4'd0});
    end
    PRESET = 1'b0;
    tick(5);
  endtask

  task automatic test_mode0();
    logic [15:0] m;
    tx_push(8'hA5);
    n_vec++;
    if (tx_ready_a !== 1'b0) begin
      n_err++; $display("FAIL m0_hold_full got %b want 0", tx_ready_a);
    end
    frame_begin(1'b0, SPI_MODE0);
    n_vec++;
    if ({frame_active_a, miso_oe_a} !== 2'b11) begin
      n_err++; $display("FAIL m0_active got %b want 11", {frame_active_a, miso_oe_a});
    end
    spi_xfer(1'b0, SPI_MODE0, 8, 8, 1'b0, 16'h003C, 1'b1, m);
    tick(3);
    n_vec++;
    if (rx_valid_a !== 1'b0) begin
      n_err++; $display("FAIL m0_rx_valid_early got %b want 0", rx_valid_a);
    end
    tick(1);
    n_vec++;
    if ({rx_valid_a, rx_data_a, bit_cnt_a} !== {1'b1, 8'h3C, 3'd0}) begin
      n_err++;
      $display("FAIL m0_rx got %b_%h_%0d want 1_3c_0", rx_valid_a, rx_data_a, bit_cnt_a);
    end
    tick(H - 4);
    sck = 1'b0;
    n_vec++;
    if (m[7:0] !== 8'hA5) begin
      n_err++; $display("FAIL m0_miso got %h want a5", m[7:0]);
    end
    frame_end(1'b0);
    // The final trailing edge reloads from an empty holding register.
    n_vec++;
    if (tx_underrun_a !== 1'b1) begin
      n_err++; $display("FAIL m0_tail_underrun got %b want 1", tx_underrun_a);
    end
    rx_pop();
  endtask

  task automatic test_mode3_back_to_back();
    logic [15:0] m1, m2;
    err_pulse();
    n_vec++;
    if (tx_underrun_a !== 1'b0) begin
      n_err++; $display("FAIL m3_clr got %b want 0", tx_underrun_a);
    end
    tx_push(8'h12);
    frame_begin(1'b0, SPI_MODE3);
    fork
      spi_xfer(1'b0, SPI_MODE3, 8, 8, 1'b0, 16'h00F0, 1'b0, m1);
      tx_push(8'h34);
    join
    n_vec++;
    if ({m1[7:0], rx_data_a, rx_valid_a} !== {8'h12, 8'hF0, 1'b1}) begin
      n_err++;
      $display("FAIL m3_word1 got %h_%h_%b want 12_f0_1", m1[7:0], rx_data_a, rx_valid_a);
    end
    rx_pop();
    spi_xfer(1'b0, SPI_MODE3, 8, 8, 1'b0, 16'h000F, 1'b0, m2);
    n_vec++;
    if ({m2[7:0], rx_data_a, rx_valid_a} !== {8'h34, 8'h0F, 1'b1}) begin
      n_err++;
      $display("FAIL m3_word2 got %h_%h_%b want 34_0f_1", m2[7:0], rx_data_a, rx_valid_a);
    end
    frame_end(1'b0);
    n_vec++;
    if (tx_underrun_a !== 1'b0) begin
      n_err++; $display("FAIL m3_underrun got %b want 0", tx_underrun_a);
    end
    rx_pop();
  endtask

  task automatic test_mode1_underrun();
    logic [15:0] m;
    frame_begin(1'b0, SPI_MODE1);
    n_vec++;
    if (tx_underrun_a !== 1'b0) begin
      n_err++; $display("FAIL m1_pre got %b want 0", tx_underrun_a);
    end
    spi_xfer(1'b0, SPI_MODE1, 8, 8, 1'b0, 16'h0099, 1'b0, m);
    n_vec++;
    if ({m[7:0], tx_underrun_a} !== {8'h00, 1'b1}) begin
      n_err++; $display("FAIL m1_underrun got %h_%b want 00_1", m[7:0], tx_underrun_a);
    end
    frame_end(1'b0);
    err_pulse();
    n_vec++;
    if (tx_underrun_a !== 1'b0) begin
      n_err++; $display("FAIL m1_clr got %b want 0", tx_underrun_a);
    end
    rx_pop();
  endtask

  task automatic test_overrun();
    logic [15:0] m;
    frame_begin(1'b0, SPI_MODE0);
    spi_xfer(1'b0, SPI_MODE0, 8, 8, 1'b0, 16'h0055, 1'b0, m);
    spi_xfer(1'b0, SPI_MODE0, 8, 8, 1'b0, 16'h00AA, 1'b0, m);
    n_vec++;
    if ({rx_valid_a, rx_data_a, rx_overrun_a} !== {1'b1, 8'h55, 1'b1}) begin
      n_err++;
      $display("FAIL ovr_first got %b_%h_%b want 1_55_1", rx_valid_a, rx_data_a, rx_overrun_a);
    end
    err_pulse();
    n_vec++;
    if (rx_overrun_a !== 1'b0) begin
      n_err++; $display("FAIL ovr_clr got %b want 0", rx_overrun_a);
    end
    spi_xfer(1'b0, SPI_MODE0, 8, 8, 1'b0, 16'h003C, 1'b1, m);
    tick(3);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    n_vec++;
    if ({rx_overrun_a, rx_data_a} !== {1'b1, 8'h55}) begin
      n_err++; $display("FAIL ovr_set_wins got %b_%h want 1_55", rx_overrun_a, rx_data_a);
    end
    tick(H - 4);
    sck = 1'b0;
    frame_end(1'b0);
    rx_pop();
    n_vec++;
    if (rx_valid_a !== 1'b0) begin
      n_err++; $display("FAIL ovr_pop got %b want 0", rx_valid_a);
    end
  endtask

  task automatic test_abort();
    logic [15:0] m;
    frame_begin(1'b0, SPI_MODE0);
    spi_xfer(1'b0, SPI_MODE0, 5, 8, 1'b0, 16'h00FF, 1'b0, m);
    n_vec++;
    if (bit_cnt_a !== 3'd5) begin
      n_err++; $display("FAIL abort_cnt5 got %0d want 5", bit_cnt_a);
    end
    frame_end(1'b0);
    n_vec++;
    if ({rx_valid_a, bit_cnt_a, miso_oe_a, miso_a} !== {1'b0, 3'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL abort_state got %b want 000000", {rx_valid_a, bit_cnt_a, miso_oe_a, miso_a});
    end
    frame_begin(1'b0, SPI_MODE0);
    spi_xfer(1'b0, SPI_MODE0, 8, 8, 1'b0, 16'h0081, 1'b0, m);
    n_vec++;
    if ({rx_valid_a, rx_data_a} !== {1'b1, 8'h81}) begin
      n_err++; $display("FAIL abort_next got %b_%h want 1_81", rx_valid_a, rx_data_a);
    end
    frame_end(1'b0);
    rx_pop();
  endtask

  task automatic test_lsb16_reset();
    logic [15:0] m;
    tx_data_b  = 16'h1234;
    tx_valid_b = 1'b1;
    tick(1);
    tx_valid_b = 1'b0;
    frame_begin(1'b1, SPI_MODE2);
    spi_xfer(1'b1, SPI_MODE2, 16, 16, 1'b1, 16'hBEEF, 1'b0, m);
    n_vec++;
    if ({m, rx_data_b, rx_valid_b} !== {16'h1234, 16'hBEEF, 1'b1}) begin
      n_err++;
      $display("FAIL lsb_word got %h_%h_%b want 1234_beef_1", m, rx_data_b, rx_valid_b);
    end
    frame_end(1'b1);
    frame_begin(1'b1, SPI_MODE2);
    spi_xfer(1'b1, SPI_MODE2, 5, 16, 1'b1, 16'h0013, 1'b0, m);
    PRESET = 1'b1;
    #1;
    n_vec++;
    if ({miso_b, miso_oe_b, rx_valid_b, tx_ready_b, frame_active_b, tx_underrun_b,
         rx_overrun_b, rx_data_b, bit_cnt_b} !== {7'b0001000, 16'h0000, 4'd0}) begin
      n_err++;
      $display("FAIL midreset_b got %b want %b", {miso_b, miso_oe_b, rx_valid_b, tx_ready_b,
               frame_active_b, tx_underrun_b, rx_overrun_b, rx_data_b, bit_cnt_b},
               {7'b0001000, 16'h0000, 4'd0});
    end
    tick(2);
    PRESET = 1'b0;
    tick(15);
    n_vec++;
    if ({frame_active_b, miso_oe_b} !== 2'b00) begin
      n_err++;
      $display("FAIL release_wait got %b want 00", {frame_active_b, miso_oe_b});
    end
    ssel_b = 1'b1;
    tick(10);
    sck = 1'b0;
    tick(5);
  endtask

  initial begin
    PRESET     = 1'b1;
    sck        = 1'b0;
    mosi       = 1'b0;
    err_clr    = 1'b0;
    ssel_a     = 1'b1;
    ssel_b     = 1'b1;
    mode_a     = SPI_MODE0;
    mode_b     = SPI_MODE0;
    tx_data_a  = '0;
    tx_data_b  = '0;
    tx_valid_a = 1'b0;
    tx_valid_b = 1'b0;
    rx_ready_a = 1'b0;
    rx_ready_b = 1'b0;
    test_reset();
    test_mode0();
    test_mode3_back_to_back();
    test_mode1_underrun();
    test_overrun();
    test_abort();
    test_lsb16_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_slave_core.md
# spi_slave_core

Parametrised SPI slave for the serial peripheral path. It supports any SPI mode, selected at runtime and latched per frame. Word width and bit order are configurable. A frame may carry back-to-back words. TX and RX use valid/ready handshakes, and sticky underrun/overrun flags report lost data. It sits between the external SPI pins and the register/FIFO logic on the system clock `clk`; SCK is treated as asynchronous data.

## Interface
- `DATA_W`, 8 — bits per word, ≥4
- `LSB_FIRST`, 0 — 0: MSB shifted first on both MOSI and MISO; 1: LSB first
- `SYNC_STAGES`, 2 — synchroniser depth for SCK, SSEL and MOSI, ≥2
- `clk` in 1 — system clock; all logic on its rising edge
- `PRESET` in 1 — reset, asynchronous, active-high
- `SCK` in 1 — SPI clock from master
- `SSEL` in 1 — slave select, active-low
- `MOSI` in 1 — serial data in
- `MISO` out 1 — serial data out; 0 when not driving
- `MISO_oe` out 1 — output enable for the pad; 1 only while a frame is active
- `mode` in 2 — {CPOL,CPHA}; latched on SSEL assertion
- `tx_data` in DATA_W — next word to transmit
- `tx_valid` in 1 / `tx_ready` out 1 — TX handshake; transfer when both are 1
- `rx_data` out DATA_W — last received word
- `rx_valid` out 1 / `rx_ready` in 1 — RX handshake; rx_data is stable while rx_valid=1
- `bit_cnt` out $clog2(DATA_W) — bits sampled in the current word
- `frame_active` out 1 — synchronised SSEL is asserted
- `tx_underrun`, `rx_overrun` out 1 — sticky error flags
- `err_clr` in 1 — clears both sticky flags (set wins over clear in the same cycle)

## Operation
- Synchronisation: SCK, SSEL and MOSI each pass through SYNC_STAGES flops. Edge detect compares the last two stages.
- Frame start is the synchronised SSEL falling edge. It latches `mode` into `mode_q`, clears bit_cnt and asserts MISO_oe.
- Frame end is the synchronised SSEL rising edge, or any cycle where SSEL is seen high. It clears bit_cnt and drops MISO_oe/MISO. A partial RX word is discarded without any flag.
- Edge classes:
  - Leading edge: SCK leaves CPOL level.
  - Trailing edge: SCK returns to CPOL level.
  - CPHA=0: sample on leading, shift on trailing.
  - CPHA=1: shift on leading, sample on trailing.
- Sample edge: shift the MOSI bit into rx_shift at the LSB_FIRST-dependent end, then bit_cnt += 1 (wraps DATA_W-1 → 0).
- Word completion: the sample edge with bit_cnt = DATA_W-1.
  - If rx_valid=0: load rx_data and set rx_valid.
  - If rx_valid=1: drop the new word, keep rx_data, set rx_overrun.
- rx_valid clears on the cycle rx_valid&&rx_ready. Completion and handshake in the same cycle: the new word loads and rx_valid stays 1.
- TX holding register (one word): tx_ready = holding empty. On tx_valid&&tx_ready, capture tx_data.
- Load points:
  - CPHA=0: frame start, and each trailing edge where bit_cnt=0 (all other trailing edges shift).
  - CPHA=1: each leading edge where bit_cnt=0 (all other leading edges shift).
- At a load point: if the holding register is full, move it to tx_shift and mark the holding register empty. Otherwise load all-zeros and set tx_underrun.
- A CPHA=0 trailing-edge load after the final word of a frame consumes the holding word. This is defined behaviour; software pre-loads only as many words as it expects to send.
- Holding write and load in the same cycle: the load takes the old contents and the write is refused, because tx_ready was 0 while the register was full.
- MISO = tx_shift[DATA_W-1] (or [0] if LSB_FIRST) while the frame is active, else 0.
- Changes to `mode` mid-frame are ignored.

## Timing
- Reset values:
  - MISO=0, MISO_oe=0
  - rx_data=0, rx_valid=0
  - tx_ready=1 (holding empty)
  - bit_cnt=0, frame_active=0
  - tx_underrun=0, rx_overrun=0
  - mode_q=0; synchroniser flops reset to SCK=0, SSEL=1, MOSI=0
- Pin-to-event latency: SYNC_STAGES+1 clk from a pin edge to the internal edge pulse. rx_valid asserts 1 clk after that, so SYNC_STAGES+2 clk after the final sampling SCK edge.
- MISO update: SYNC_STAGES+2 clk after the shift edge. This requires SCK half-period ≥ SYNC_STAGES+3 clk periods; for defaults, SCK ≤ clk/10.
- Reset asserted mid-frame returns every output to its reset value immediately. Reset release mid-frame waits for the next SSEL assertion before a frame starts.

## Structure
- Package `spi_pkg`:
  - mode constants SPI_MODE0..3
  - CPOL/CPHA bit indices
  - `cnt_w(DATA_W)` function
- Sub-module `spi_sync`: parametrised N-stage synchroniser plus rise/fall detector, one instance each for SCK, SSEL and MOSI (MOSI uses only the level output).

## Test plan
- Mode 0, DATA_W=8, tx 0xA5 preloaded, master sends 0x3C → MISO bits 1010_0101; rx_data=0x3C with rx_valid 4 clk after 8th rising SCK; bit_cnt ends 0.
- Mode 3, two-word frame, tx 0x12 then 0x34 written via handshake, master sends 0xF0, 0x0F → rx sequence 0xF0, 0x0F; MISO 0x12, 0x34; tx_underrun=0.
- Mode 1, tx never written → MISO all 0, tx_underrun=1 after the first leading edge; err_clr pulse → flag 0.
- rx_ready held 0 over two words 0x55, 0xAA → rx_data=0x55, rx_overrun=1; err_clr with a simultaneous overrun keeps the flag 1.
- SSEL deasserted after 5 bits → no rx_valid, bit_cnt=0, MISO_oe=0; next frame receives 0x81 correctly.
- DATA_W=16, LSB_FIRST=1, mode 2, master sends 0xBEEF LSB first, with PRESET pulsed in a second frame mid-word → first rx_data=0xBEEF; after reset all outputs at reset values, tx_ready=1.
